// File: rtl/inert_pkg.sv
// ---------------------------------------------------------------------------
// inert_pkg
// Shared definitions for the inertial-sensor sequencer:
//   - state_t     : sequencer state encoding
//   - CMD_*       : the four configuration write commands, in issue order
//   - ADDR_*      : sensor register addresses read on every data-ready event
//   - RD_BIT      : MSB of a command word that marks it as a register read
//   - cfgCmd()    : configuration command for a given write step
//   - rdCmd()     : read command for a given read step
// ---------------------------------------------------------------------------
package inert_pkg;

    // Sequencer states. The order matters only for readability: power-up,
    // configuration, then the steady-state read loop.
    typedef enum logic [2:0] {
        PWR_WAIT,
        CFG_ISSUE,
        CFG_WAIT,
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        PUBLISH
    } state_t;

    // Configuration writes: interrupt enable first so the sensor starts
    // raising data-ready as soon as it is configured.
    localparam logic [15:0] CMD_INT_EN    = 16'h0D02;
    localparam logic [15:0] CMD_ACCEL_CFG = 16'h1053;
    localparam logic [15:0] CMD_GYRO_CFG  = 16'h1150;
    localparam logic [15:0] CMD_ROUND_CFG = 16'h1460;

    // Sensor registers read on every data-ready event.
    localparam logic [6:0] ADDR_PTCH_L = 7'h22;
    localparam logic [6:0] ADDR_PTCH_H = 7'h23;
    localparam logic [6:0] ADDR_AZ_L   = 7'h2C;
    localparam logic [6:0] ADDR_AZ_H   = 7'h2D;

    localparam logic RD_BIT = 1'b1;

    // Write command for configuration step 0..3.
    function automatic logic [15:0] cfgCmd(input logic [1:0] step);
        logic [15:0] word;
        case (step)
            2'd0:    word = CMD_INT_EN;
            2'd1:    word = CMD_ACCEL_CFG;
            2'd2:    word = CMD_GYRO_CFG;
            default: word = CMD_ROUND_CFG;
        endcase
        return word;
    endfunction

    // Read command for read step 0..3: pitch low/high, then AZ low/high.
    // The step number doubles as the staging-byte index.
    function automatic logic [15:0] rdCmd(input logic [1:0] step);
        logic [6:0] addr;
        case (step)
            2'd0:    addr = ADDR_PTCH_L;
            2'd1:    addr = ADDR_PTCH_H;
            2'd2:    addr = ADDR_AZ_L;
            default: addr = ADDR_AZ_H;
        endcase
        return {RD_BIT, addr, 8'h00};
    endfunction

endpackage

// File: rtl/int_sync.sv
// ---------------------------------------------------------------------------
// int_sync
// Brings the asynchronous sensor interrupt into the clk domain and produces
// a one-cycle pulse on each rising edge.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (all flops clear to 0)
//   i_async  in   raw interrupt line, asynchronous to clk
//   o_rise   out  one-cycle pulse, high for one clock per synchronized rising edge
// ---------------------------------------------------------------------------
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Two flops for metastability settling, a third holding the previous
    // synchronized level so the edge can be detected without glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/inert_seq_ctrl.sv
// ---------------------------------------------------------------------------
// inert_seq_ctrl
// Sequencer between the 16-bit SPI master and the pitch integrator. Waits
// for sensor power-up, writes the four configuration commands, then services
// each data-ready interrupt with a four-byte read burst and publishes the
// assembled pitch-rate and Z-acceleration words with a one-cycle strobe.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   INT       in   sensor data-ready interrupt (asynchronous, active-high)
//   done      in   SPI transaction-complete pulse
//   rd_data   in   [7:0]  low byte of the SPI response, valid with done
//   wrt       out  one-cycle pulse starting an SPI transaction
//   cmd       out  [15:0] SPI command word, held from wrt until done
//   ptch_rt   out  [15:0] signed raw pitch rate {high, low}
//   AZ        out  [15:0] signed raw Z acceleration {high, low}
//   vld       out  one-cycle strobe marking a new ptch_rt/AZ pair
// Parameters:
//   INIT_CNT_W  width of the power-up wait counter (wait = 2^INIT_CNT_W clocks)
// ---------------------------------------------------------------------------
module inert_seq_ctrl
    import inert_pkg::*;
#(
    parameter int INIT_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [7:0]  rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
);

    state_t                  r_state;
    logic [INIT_CNT_W-1:0]   r_pwrCnt;
    logic [1:0]              r_step;
    logic [3:0][7:0]         r_stage;
    logic                    r_pending;
    logic                    r_wrt;
    logic                    r_vld;
    logic [15:0]             r_cmd;
    logic [15:0]             r_ptchRt;
    logic [15:0]             r_az;

    logic                    w_intRise;
    logic                    w_armed;

    int_sync u_intSync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (INT),
        .o_rise  (w_intRise)
    );

    // Interrupts are only meaningful once the sensor is configured; edges
    // seen during power-up or configuration are dropped.
    assign w_armed = (r_state == IDLE)    || (r_state == RD_ISSUE) ||
                     (r_state == RD_WAIT) || (r_state == PUBLISH);

    // Main sequencer. wrt and vld default low each cycle and are raised only
    // on the transition into an ISSUE state or into PUBLISH, which makes them
    // exact one-cycle pulses aligned with the state they announce.
    //
    // The pending flag lives here because its clear is tied to the
    // IDLE -> RD_ISSUE transition; a new edge in that same cycle takes
    // priority so an interrupt is never lost, and any number of edges during
    // a burst fold into one follow-up burst.
    //
    // The last read byte is taken straight from rd_data while the other three
    // come from staging, so the published words and vld appear the cycle
    // after the final done while PUBLISH is the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PWR_WAIT;
            r_pwrCnt  <= '0;
            r_step    <= 2'd0;
            r_stage   <= '0;
            r_pending <= 1'b0;
            r_wrt     <= 1'b0;
            r_vld     <= 1'b0;
            r_cmd     <= 16'h0000;
            r_ptchRt  <= 16'h0000;
            r_az      <= 16'h0000;
        end else begin
            r_wrt <= 1'b0;
            r_vld <= 1'b0;

            if (w_intRise && w_armed) begin
                r_pending <= 1'b1;
            end else if ((r_state == IDLE) && r_pending) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                PWR_WAIT: begin
                    r_pwrCnt <= r_pwrCnt + 1'b1;
                    if (&r_pwrCnt) begin
                        r_state <= CFG_ISSUE;
                        r_step  <= 2'd0;
                        r_wrt   <= 1'b1;
                        r_cmd   <= cfgCmd(2'd0);
                    end
                end

                CFG_ISSUE: begin
                    r_state <= CFG_WAIT;
                end

                CFG_WAIT: begin
                    if (done) begin
                        if (r_step == 2'd3) begin
                            r_state <= IDLE;
                            r_step  <= 2'd0;
                        end else begin
                            r_state <= CFG_ISSUE;
                            r_step  <= r_step + 2'd1;
                            r_wrt   <= 1'b1;
                            r_cmd   <= cfgCmd(r_step + 2'd1);
                        end
                    end
                end

                IDLE: begin
                    if (r_pending) begin
                        r_state <= RD_ISSUE;
                        r_step  <= 2'd0;
                        r_wrt   <= 1'b1;
                        r_cmd   <= rdCmd(2'd0);
                    end
                end

                RD_ISSUE: begin
                    r_state <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (done) begin
                        r_stage[r_step] <= rd_data;
                        if (r_step == 2'd3) begin
                            r_state  <= PUBLISH;
                            r_step   <= 2'd0;
                            r_ptchRt <= {r_stage[1], r_stage[0]};
                            r_az     <= {rd_data, r_stage[2]};
                            r_vld    <= 1'b1;
                        end else begin
                            r_state <= RD_ISSUE;
                            r_step  <= r_step + 2'd1;
                            r_wrt   <= 1'b1;
                            r_cmd   <= rdCmd(r_step + 2'd1);
                        end
                    end
                end

                PUBLISH: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= PWR_WAIT;
                end
            endcase
        end
    end

    assign wrt     = r_wrt;
    assign vld     = r_vld;
    assign cmd     = r_cmd;
    assign ptch_rt = r_ptchRt;
    assign AZ      = r_az;

endmodule

// File: tb/tb_inert_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inert_seq_ctrl
// Self-checking bench for inert_seq_ctrl. A sensor model holds a register
// image that the SPI responder serves on reads; expected published words
// are computed from that image with plain arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inert_seq_ctrl;

    localparam int W = 4;

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [7:0]  rd_data;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;

    int checks;
    int passes;
    int cyc;

    // Sensor register image and SPI responder bookkeeping
    logic [7:0]  regImg [0:127];
    logic [15:0] cmdLog [$];
    int          doneCnt;
    int          extraWrt;
    int          cmdChange;
    int          lastDoneCyc;
    int          latMin;
    int          latMax;
    int          spurReq;
    int          spurAck;

    // Output monitor bookkeeping
    logic [31:0] vldQ [$];
    int          vldCycQ [$];
    int          vldDouble;
    int          holdViol;

    logic [15:0] cfgSeq [4];
    logic [15:0] rdSeq  [4];

    inert_seq_ctrl #(.INIT_CNT_W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Sensor-side SPI responder: logs each command, answers after a random
    // latency, and watches that wrt does not repeat and cmd stays put.
    initial begin
        logic [15:0] heldCmd;
        int          lat;
        bit          aborted;
        done    = 1'b0;
        rd_data = 8'h00;
        @(negedge clk);
        forever begin
            if (spurAck != spurReq) begin
                rd_data = 8'($urandom);
                done    = 1'b1;
                @(negedge clk);
                done    = 1'b0;
                spurAck++;
            end else if (rst_n === 1'b1 && wrt === 1'b1) begin
                heldCmd = cmd;
                cmdLog.push_back(cmd);
                lat     = $urandom_range(latMax, latMin);
                aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (wrt === 1'b1) extraWrt++;
                    if (cmd !== heldCmd) cmdChange++;
                end
                if (!aborted) begin
                    rd_data     = heldCmd[15] ? regImg[heldCmd[14:8]] : 8'($urandom);
                    done        = 1'b1;
                    lastDoneCyc = cyc;
                    doneCnt++;
                    @(negedge clk);
                    done = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    // Output monitor: records every vld pair and flags outputs that move
    // outside a vld cycle.
    initial begin
        logic        prevVld;
        logic        prevRst;
        logic [15:0] prevP;
        logic [15:0] prevA;
        prevVld = 1'b0;
        prevRst = 1'b0;
        prevP   = 16'h0;
        prevA   = 16'h0;
        forever begin
            @(negedge clk);
            if (vld === 1'b1) begin
                vldQ.push_back({ptch_rt, AZ});
                vldCycQ.push_back(cyc);
                if (prevVld) vldDouble++;
            end else if (rst_n === 1'b1 && prevRst === 1'b1 &&
                         (ptch_rt !== prevP || AZ !== prevA)) begin
                holdViol++;
            end
            prevVld = (vld === 1'b1);
            prevRst = rst_n;
            prevP   = ptch_rt;
            prevA   = AZ;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected {ptch_rt, AZ} from the current sensor register image.
    function automatic logic [31:0] expectedPair();
        int p;
        int a;
        p = int'(regImg[7'h23]) * 256 + int'(regImg[7'h22]);
        a = int'(regImg[7'h2D]) * 256 + int'(regImg[7'h2C]);
        return {p[15:0], a[15:0]};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseInt(input int highCycles);
        @(negedge clk);
        INT = 1'b1;
        repeat (highCycles) @(negedge clk);
        INT = 1'b0;
    endtask

    task automatic randomizeImage();
        regImg[7'h22] = 8'($urandom_range(0, 255));
        regImg[7'h23] = 8'($urandom_range(0, 255));
        regImg[7'h2C] = 8'($urandom_range(0, 255));
        regImg[7'h2D] = 8'($urandom_range(0, 255));
    endtask

    task automatic waitCmds(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cmdLog.size() >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic waitVlds(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (vldQ.size() >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic waitDones(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (doneCnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Releases reset and counts clock edges until the first wrt; -1 if none.
    task automatic releaseAndTimeFirstWrt(output int n);
        @(negedge clk);
        rst_n = 1'b1;
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (wrt === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        INT   = 1'b0;
        idle(3);
        checks++; if (wrt !== 1'b0) $display("[TB] FAIL reset_wrt: got %b want 0", wrt); else passes++;
        checks++; if (vld !== 1'b0) $display("[TB] FAIL reset_vld: got %b want 0", vld); else passes++;
        checks++; if (cmd !== 16'h0000) $display("[TB] FAIL reset_cmd: got %h want 0000", cmd); else passes++;
        checks++; if (ptch_rt !== 16'h0000) $display("[TB] FAIL reset_ptch: got %h want 0000", ptch_rt); else passes++;
        checks++; if (AZ !== 16'h0000) $display("[TB] FAIL reset_az: got %h want 0000", AZ); else passes++;
    endtask

    // Power-up timing, configuration order, and INT edges during config.
    // The first wrt is seen after edge 2^W, i.e. in clock cycle 2^W+1.
    task automatic test_config();
        int base, dbase, vb, n;
        bit ok;
        logic [15:0] got;
        latMin = 3;
        latMax = 4;
        base  = cmdLog.size();
        dbase = doneCnt;
        vb    = vldQ.size();
        releaseAndTimeFirstWrt(n);
        checks++; if (n != (1 << W)) $display("[TB] FAIL first_wrt_time: got %0d want %0d", n, 1 << W); else passes++;
        waitCmds(base + 2, 200, ok);
        checks++; if (!ok) $display("[TB] FAIL cfg_second_wrt: got timeout want wrt"); else passes++;
        pulseInt(2);
        idle(2);
        pulseInt(2);
        waitDones(dbase + 4, 300, ok);
        checks++; if (!ok) $display("[TB] FAIL cfg_done_count: got %0d want %0d", doneCnt - dbase, 4); else passes++;
        idle(40);
        checks++; if (cmdLog.size() != base + 4) $display("[TB] FAIL cfg_no_burst: got %0d cmds want %0d", cmdLog.size() - base, 4); else passes++;
        for (int k = 0; k < 4; k++) begin
            got = (base + k < cmdLog.size()) ? cmdLog[base + k] : 'x;
            checks++; if (got !== cfgSeq[k]) $display("[TB] FAIL cfg_cmd%0d: got %h want %h", k, got, cfgSeq[k]); else passes++;
        end
        checks++; if (doneCnt - dbase != cmdLog.size() - base) $display("[TB] FAIL cfg_wrt_per_done: got %0d wrt want %0d", cmdLog.size() - base, doneCnt - dbase); else passes++;
        checks++; if (vldQ.size() != vb) $display("[TB] FAIL cfg_no_vld: got %0d want 0", vldQ.size() - vb); else passes++;
    endtask

    task automatic test_single_read();
        int base, vb;
        bit ok;
        logic [15:0] got;
        logic [31:0] pair;
        latMin = 1;
        latMax = 4;
        regImg[7'h22] = 8'h34;
        regImg[7'h23] = 8'h12;
        regImg[7'h2C] = 8'hCD;
        regImg[7'h2D] = 8'hAB;
        base = cmdLog.size();
        vb   = vldQ.size();
        pulseInt(2);
        waitVlds(vb + 1, 300, ok);
        checks++; if (!ok) $display("[TB] FAIL single_vld: got timeout want vld"); else passes++;
        idle(20);
        checks++; if (vldQ.size() != vb + 1) $display("[TB] FAIL single_vld_count: got %0d want 1", vldQ.size() - vb); else passes++;
        checks++; if (cmdLog.size() != base + 4) $display("[TB] FAIL single_cmd_count: got %0d want 4", cmdLog.size() - base); else passes++;
        for (int k = 0; k < 4; k++) begin
            got = (base + k < cmdLog.size()) ? cmdLog[base + k] : 'x;
            checks++; if (got !== rdSeq[k]) $display("[TB] FAIL single_rd_cmd%0d: got %h want %h", k, got, rdSeq[k]); else passes++;
        end
        pair = (vb < vldQ.size()) ? vldQ[vb] : 'x;
        checks++; if (pair[31:16] !== 16'h1234) $display("[TB] FAIL single_ptch: got %h want 1234", pair[31:16]); else passes++;
        checks++; if (pair[15:0] !== 16'hABCD) $display("[TB] FAIL single_az: got %h want abcd", pair[15:0]); else passes++;
        if (vb < vldCycQ.size()) begin
            checks++; if (vldCycQ[vb] - lastDoneCyc != 1) $display("[TB] FAIL single_vld_latency: got %0d want 1", vldCycQ[vb] - lastDoneCyc); else passes++;
        end
    endtask

    task automatic test_random_reads();
        int base, vb;
        bit ok;
        logic [31:0] exp, pair;
        latMin = 1;
        latMax = 3;
        for (int it = 0; it < 4; it++) begin
            randomizeImage();
            exp  = expectedPair();
            base = cmdLog.size();
            vb   = vldQ.size();
            pulseInt($urandom_range(1, 3));
            waitVlds(vb + 1, 300, ok);
            idle(15);
            checks++; if (!ok) $display("[TB] FAIL rand%0d_vld: got timeout want vld", it); else passes++;
            pair = (vb < vldQ.size()) ? vldQ[vb] : 'x;
            checks++; if (pair[31:16] !== exp[31:16]) $display("[TB] FAIL rand%0d_ptch: got %h want %h", it, pair[31:16], exp[31:16]); else passes++;
            checks++; if (pair[15:0] !== exp[15:0]) $display("[TB] FAIL rand%0d_az: got %h want %h", it, pair[15:0], exp[15:0]); else passes++;
            checks++; if (cmdLog.size() != base + 4) $display("[TB] FAIL rand%0d_cmd_count: got %0d want 4", it, cmdLog.size() - base); else passes++;
        end
    endtask

    // Two INT edges during one burst give exactly one further burst.
    task automatic test_back_to_back();
        int base, vb;
        bit ok;
        logic [31:0] expA, expB, pair;
        logic [15:0] got;
        latMin = 4;
        latMax = 4;
        randomizeImage();
        expA = expectedPair();
        base = cmdLog.size();
        vb   = vldQ.size();
        pulseInt(2);
        waitCmds(base + 1, 50, ok);
        checks++; if (!ok) $display("[TB] FAIL b2b_first_wrt: got timeout want wrt"); else passes++;
        pulseInt(2);
        idle(3);
        pulseInt(2);
        waitVlds(vb + 1, 300, ok);
        randomizeImage();
        expB = expectedPair();
        waitVlds(vb + 2, 300, ok);
        idle(40);
        checks++; if (vldQ.size() != vb + 2) $display("[TB] FAIL b2b_vld_count: got %0d want 2", vldQ.size() - vb); else passes++;
        checks++; if (cmdLog.size() != base + 8) $display("[TB] FAIL b2b_cmd_count: got %0d want 8", cmdLog.size() - base); else passes++;
        pair = (vb < vldQ.size()) ? vldQ[vb] : 'x;
        checks++; if (pair !== expA) $display("[TB] FAIL b2b_pair1: got %h want %h", pair, expA); else passes++;
        pair = (vb + 1 < vldQ.size()) ? vldQ[vb + 1] : 'x;
        checks++; if (pair !== expB) $display("[TB] FAIL b2b_pair2: got %h want %h", pair, expB); else passes++;
        for (int k = 0; k < 4; k++) begin
            got = (base + 4 + k < cmdLog.size()) ? cmdLog[base + 4 + k] : 'x;
            checks++; if (got !== rdSeq[k]) $display("[TB] FAIL b2b_rd_cmd%0d: got %h want %h", k, got, rdSeq[k]); else passes++;
        end
    endtask

    // Reset while waiting for the AZ high byte: nothing published, full restart.
    task automatic test_reset_mid_burst();
        int base, vb, dbase, n;
        bit ok;
        logic [15:0] got;
        latMin = 6;
        latMax = 6;
        randomizeImage();
        base  = cmdLog.size();
        vb    = vldQ.size();
        dbase = doneCnt;
        pulseInt(2);
        waitCmds(base + 4, 200, ok);
        checks++; if (!ok) $display("[TB] FAIL rst_reach_az_high: got timeout want wrt"); else passes++;
        idle(2);
        rst_n = 1'b0;
        idle(1);
        checks++; if (vld !== 1'b0) $display("[TB] FAIL rst_mid_vld: got %b want 0", vld); else passes++;
        checks++; if (wrt !== 1'b0) $display("[TB] FAIL rst_mid_wrt: got %b want 0", wrt); else passes++;
        checks++; if (cmd !== 16'h0000) $display("[TB] FAIL rst_mid_cmd: got %h want 0000", cmd); else passes++;
        checks++; if (ptch_rt !== 16'h0000) $display("[TB] FAIL rst_mid_ptch: got %h want 0000", ptch_rt); else passes++;
        checks++; if (AZ !== 16'h0000) $display("[TB] FAIL rst_mid_az: got %h want 0000", AZ); else passes++;
        idle(2);
        latMin = 1;
        latMax = 3;
        releaseAndTimeFirstWrt(n);
        checks++; if (n != (1 << W)) $display("[TB] FAIL rst_restart_time: got %0d want %0d", n, 1 << W); else passes++;
        waitDones(dbase + 7, 300, ok);
        idle(40);
        checks++; if (!ok) $display("[TB] FAIL rst_cfg_dones: got %0d want 7", doneCnt - dbase); else passes++;
        checks++; if (cmdLog.size() != base + 8) $display("[TB] FAIL rst_cmd_count: got %0d want 8", cmdLog.size() - base); else passes++;
        for (int k = 0; k < 4; k++) begin
            got = (base + 4 + k < cmdLog.size()) ? cmdLog[base + 4 + k] : 'x;
            checks++; if (got !== cfgSeq[k]) $display("[TB] FAIL rst_cfg_cmd%0d: got %h want %h", k, got, cfgSeq[k]); else passes++;
        end
        checks++; if (vldQ.size() != vb) $display("[TB] FAIL rst_no_vld: got %0d want 0", vldQ.size() - vb); else passes++;
    endtask

    // done while idle must not start anything; the next INT still works.
    task automatic test_spurious_done();
        int base, vb;
        bit ok;
        logic [31:0] exp, pair;
        logic [15:0] got;
        latMin = 1;
        latMax = 3;
        idle(10);
        base = cmdLog.size();
        vb   = vldQ.size();
        spurReq++;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (spurAck == spurReq) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!ok) $display("[TB] FAIL spur_sent: got timeout want done pulse"); else passes++;
        idle(20);
        checks++; if (cmdLog.size() != base) $display("[TB] FAIL spur_no_wrt: got %0d want 0", cmdLog.size() - base); else passes++;
        checks++; if (vldQ.size() != vb) $display("[TB] FAIL spur_no_vld: got %0d want 0", vldQ.size() - vb); else passes++;
        randomizeImage();
        exp = expectedPair();
        pulseInt(2);
        waitVlds(vb + 1, 300, ok);
        idle(15);
        got = (base < cmdLog.size()) ? cmdLog[base] : 'x;
        checks++; if (got !== rdSeq[0]) $display("[TB] FAIL spur_next_cmd: got %h want %h", got, rdSeq[0]); else passes++;
        checks++; if (cmdLog.size() != base + 4) $display("[TB] FAIL spur_next_count: got %0d want 4", cmdLog.size() - base); else passes++;
        pair = (vb < vldQ.size()) ? vldQ[vb] : 'x;
        checks++; if (pair !== exp) $display("[TB] FAIL spur_next_pair: got %h want %h", pair, exp); else passes++;
    endtask

    task automatic test_protocol_integrity();
        checks++; if (extraWrt != 0) $display("[TB] FAIL wrt_single_pulse: got %0d extra want 0", extraWrt); else passes++;
        checks++; if (cmdChange != 0) $display("[TB] FAIL cmd_held: got %0d changes want 0", cmdChange); else passes++;
        checks++; if (vldDouble != 0) $display("[TB] FAIL vld_single_pulse: got %0d long want 0", vldDouble); else passes++;
        checks++; if (holdViol != 0) $display("[TB] FAIL outputs_hold: got %0d changes want 0", holdViol); else passes++;
    endtask

    initial begin
        rst_n  = 1'b0;
        INT    = 1'b0;
        latMin = 1;
        latMax = 1;
        cfgSeq = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
        rdSeq  = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
        for (int a = 0; a < 128; a++) regImg[a] = 8'h00;

        test_reset();
        test_config();
        test_single_read();
        test_random_reads();
        test_back_to_back();
        test_reset_mid_burst();
        test_spurious_done();
        test_protocol_integrity();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inert_seq_ctrl.md
# inert_seq_ctrl

Sequencer between the 16-bit SPI master and the pitch integrator. After reset it waits for sensor power-up, writes four configuration commands to the inertial sensor, then services every data-ready interrupt. Each service reads pitch-rate and Z-acceleration low/high bytes over SPI. It presents the assembled `ptch_rt` and `AZ` words with a one-cycle `vld` strobe, which is the integrator's update enable.

## Interface
- `INIT_CNT_W`, default 16. Width of the power-up wait counter; the wait is 2^INIT_CNT_W clocks.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `INT`  input  1  sensor data-ready interrupt; asynchronous to `clk`; active-high.
- `done`  input  1  SPI master transaction-complete pulse, one cycle.
- `rd_data`  input  8  low byte of the SPI response; valid in the cycle `done` is high.
- `wrt`  output  1  one-cycle pulse that starts an SPI transaction.
- `cmd`  output  16  SPI command word; held stable from `wrt` until `done`.
- `ptch_rt`  output  16  signed raw pitch rate, {high byte, low byte}.
- `AZ`  output  16  signed raw Z acceleration, {high byte, low byte}.
- `vld`  output  1  one-cycle strobe: a new `ptch_rt`/`AZ` pair is available.

## Operation
- Write commands, issued in this order:
  - `16'h0D02`: data-ready interrupt enable.
  - `16'h1053`: accelerometer configuration.
  - `16'h1150`: gyro configuration.
  - `16'h1460`: rounding configuration.
- Read command format: {1'b1, addr[6:0], 8'h00}.
- Read sequence: `16'hA200` pitch low, `16'hA300` pitch high, `16'hAC00` AZ low, `16'hAD00` AZ high.
- States:
  - `PWR_WAIT`: the counter increments every cycle. Leave when the counter is all-ones.
  - `CFG_ISSUE`/`CFG_WAIT`: shared by the 4 writes, indexed by a 2-bit step counter. After the 4th `done`, go to `IDLE`.
  - `IDLE`: wait for a pending interrupt.
  - `RD_ISSUE`/`RD_WAIT`: shared by the 4 reads, indexed by a 2-bit step counter. On each `done`, capture `rd_data` into the staging byte selected by the step.
  - `PUBLISH`: copy the staging bytes to `ptch_rt`/`AZ`, pulse `vld`, then return to `IDLE`.
- `wrt` is high for exactly one cycle, in the cycle an ISSUE state is entered.
- `done` is ignored in every state except `CFG_WAIT` and `RD_WAIT`.
- `INT` handling:
  - `INT` is double-flopped, then rising-edge detected.
  - A rising edge sets the `pending` flag in any state at or after `IDLE`.
  - Edges during `PWR_WAIT`/`CFG_*` are discarded.
  - Leaving `IDLE` for `RD_ISSUE` clears `pending`.
  - An edge in the same cycle as the clear wins: `pending` stays set.
  - An edge during a read burst therefore triggers exactly one further burst. Multiple edges during one burst collapse into one.
- Reset values:
  - `wrt`=0, `vld`=0, `cmd`=`16'h0000`.
  - `ptch_rt`=0, `AZ`=0, staging=0, `pending`=0.
  - State=`PWR_WAIT`, counters=0.
- Reset mid-transaction returns to `PWR_WAIT` and re-runs full configuration. No partial data is published.
- Outputs `ptch_rt`/`AZ` change only in the `vld` cycle and hold otherwise.

## Timing
- Power-up to the first `wrt` is 2^INIT_CNT_W + 1 clocks.
- Each ISSUE state lasts 1 cycle; the WAIT state is entered the next cycle.
- After a WAIT `done`, the next ISSUE follows on the next cycle.
- `vld` rises on the cycle after the 4th read `done`.
- `INT` to `pending` latency is 3 clocks (2 sync + 1 edge register).
- Idle `pending` to `wrt` latency is 1 clock.

## Structure
- Package `inert_pkg` holds:
  - the state enum;
  - the four config command constants;
  - the four register-address constants;
  - the read-bit constant.
- Sub-module `int_sync`: double-flop synchronizer plus rising-edge detector, with reset to 0. The rest is one FSM module.

## Test plan
- Reset, then run to completion with `INIT_CNT_W`=4 → the first `wrt` occurs at cycle 17; the SPI model records `0D02`, `1053`, `1150`, `1460` in order, one `wrt` per `done`.
- `INT` pulse after configuration, with `rd_data` returning 34, 12, CD, AB → `cmd` sequence `A200`, `A300`, `AC00`, `AD00`; `vld` one cycle later with `ptch_rt`=`16'h1234` and `AZ`=`16'hABCD`.
- `INT` toggled during `CFG_WAIT` → no read burst follows configuration; `vld` never asserts.
- Two `INT` edges during one read burst → exactly two bursts total and two `vld` pulses.
- `rst_n` asserted during `RD_WAIT` of the high AZ byte → `vld` stays 0, outputs clear to 0, and the sequence restarts at `PWR_WAIT`.
- Spurious `done` in `IDLE` → no state change and no `wrt`.
